fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of instruction_memory and owns the program counter.
- Drives the PC onto the instruction_memory address input, which has a combinational read.
- Captures the returned word and its PC into a small FIFO that feeds decode through a valid/ready handshake.
- Handles branch/jump redirects (flushing the FIFO) and traps misaligned redirect targets into a fault state.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- BUF_DEPTH, 2, fetch FIFO entries; power of two, minimum 2.
- XLEN comes from riscv_pkg (32); it is not a module parameter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- imem_addr_o  out  XLEN  fetch address to instruction_memory pc_in; always equals the internal PC register.
- imem_rdata_i  in  XLEN  instruction word returned combinationally for imem_addr_o.
- redirect_i  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc_i  in  XLEN  redirect target.
- id_valid_o  out  1  FIFO head is valid.
- id_ready_i  in  1  decode accepts the head.
- id_instr_o  out  XLEN  head instruction.
- id_pc_o  out  XLEN  head PC.
- id_pc4_o  out  XLEN  head PC + 4, modulo 2^XLEN.
- fault_o  out  1  misaligned-target fault state.
- fetch_cnt_o  out  32  fetched-word counter; see Optional Feature.
- stall_cnt_o  out  32  backpressure-cycle counter; see Optional Feature.

Behaviour:
Reset values (applied when rst_ni=0 at an edge):
- pc = RESET_VECTOR, FIFO count = 0, read/write pointers = 0.
- State RUN; id_valid_o = 0, fault_o = 0, both counters = 0.
- rst_ni overrides everything, including a mid-stream redirect or a full FIFO.

FSM states: RUN, FAULT.

Definitions:
- pop = id_valid_o & id_ready_i.
- push = (state==RUN) & ~redirect_i & ((count < BUF_DEPTH) | pop).

Push:
- On push, write {imem_rdata_i, pc} at the write pointer.
- pc <= pc + 4, wrapping modulo 2^XLEN (0xFFFF_FFFC -> 0x0).

Stall:
- If FIFO is full and there is no pop, pc holds and imem_addr_o stays stable.
- Entries are never dropped or duplicated.

Pop:
- Advance the read pointer.
- Simultaneous push and pop leave the count unchanged, even when full.

Redirect (redirect_i=1 at an edge; takes priority over push):
- FIFO flushes: count = 0, pointers = 0. A same-cycle pop is still treated as consumed by decode.
- Aligned target (redirect_pc_i[1:0]==0): pc <= redirect_pc_i, state RUN.
- Misaligned target: pc <= {redirect_pc_i[XLEN-1:2], 2'b00}, state FAULT.

FAULT state:
- No pushes; id_valid_o falls to 0 once the FIFO is flushed; fault_o = 1.
- Leaves FAULT only on an aligned redirect (-> RUN) or on reset.
- A misaligned redirect while in FAULT stays in FAULT and updates pc.

Latency:
- First reset-release edge: pushes RESET_VECTOR. id_valid_o = 1 in the following cycle.
- Redirect at edge N: imem_addr_o = target during cycle N+1, target pushed at edge N+1, id_valid_o with target PC in cycle N+2.
- Flushed entries are never presented valid after the redirect edge.

Throughput: one instruction per cycle sustained while id_ready_i = 1.

Output drive: id_instr_o, id_pc_o and id_pc4_o come from FIFO head storage, not from imem_rdata_i. Their values are don't-care while id_valid_o = 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_cnt_o increments on every push.
  - stall_cnt_o increments every cycle with id_valid_o=1 & id_ready_i=0.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and clear on reset. Redirects do not clear them.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised.

Test Plan:
1. Reset, RESET_VECTOR=0, test_1.hex loaded, id_ready_i=1.
   -> id_valid_o high from the second cycle after release; id_pc_o = 0,4,8,...; id_instr_o equals file words in order; id_pc4_o = id_pc_o+4.
2. id_ready_i=0 for 5 cycles after the first valid (BUF_DEPTH=2).
   -> imem_addr_o holds at 0x8 and id_pc_o holds at 0x0. On release, the sequence is 0x0,0x4,0x8 with no gap, drop or duplicate.
3. Redirect pulse to 0x40 with FIFO holding 2 entries.
   -> id_valid_o=0 the next cycle; the next valid head has id_pc_o=0x40 and instr=word[16]; the flushed PCs never appear.
4. Redirect to 0x42.
   -> fault_o=1 and id_valid_o=0 next cycle; imem_addr_o=0x40 held.
   Then redirect to 0x80 -> fault_o=0 and the next valid id_pc_o=0x80.
5. rst_ni=0 for one edge mid-stream with FIFO full.
   -> next cycle id_valid_o=0, imem_addr_o=RESET_VECTOR, fault_o=0; fetch resumes from 0 after release.
6. With FETCH_PERF_CNT_EN: 10 streaming cycles including 3 cycles of id_ready_i=0 with valid high.
   -> stall_cnt_o=3 and fetch_cnt_o equals the observed push count.
   Without the macro, both outputs read 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures imem words into a small FIFO feeding decode.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
package riscv_pkg;
    localparam int XLEN = 32;
endpackage

module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              BUF_DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc4_o,
    output logic            fault_o,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     stall_cnt_o
);
    localparam int            PW   = $clog2(BUF_DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(BUF_DEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [PW:0]       count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0]   instr_mem [BUF_DEPTH];
    logic [XLEN-1:0]   pc_mem    [BUF_DEPTH];
    logic              pop, push;

    assign imem_addr_o = pc_q;
    assign id_valid_o  = (count_q != '0);
    assign id_instr_o  = instr_mem[rd_ptr_q];
    assign id_pc_o     = pc_mem[rd_ptr_q];
    assign id_pc4_o    = pc_mem[rd_ptr_q] + XLEN'(4);
    assign fault_o     = (state_q == FAULT);

    assign pop  = id_valid_o & id_ready_i;
    // Room is freed by a same-cycle pop, so a full FIFO still streams at one per cycle.
    assign push = (state_q == RUN) & ~redirect_i & ((count_q < FULL) | pop);

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_i) begin
            pc_d     = {redirect_pc_i[XLEN-1:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + XLEN'(4);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (PW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            pc_q     <= RESET_VECTOR;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (redirect_i) begin
                state_q <= (redirect_pc_i[1:0] == 2'b00) ? RUN : FAULT;
            end
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]    <= pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (id_valid_o && !id_ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign fetch_cnt_o = 32'h0;
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a queue-based fetch model.
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0000;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect, ready;
    logic [31:0] target;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc4, fetch_cnt, stall_cnt;
    logic        id_valid, fault;
    logic [31:0] imem [256];

    assign imem_rdata = imem[imem_addr[9:2]];

    fetch_unit #(.RESET_VECTOR(RV), .BUF_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(target),
        .id_valid_o   (id_valid),
        .id_ready_i   (ready),
        .id_instr_o   (id_instr),
        .id_pc_o      (id_pc),
        .id_pc4_o     (id_pc4),
        .fault_o      (fault),
        .fetch_cnt_o  (fetch_cnt),
        .stall_cnt_o  (stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a pair of queues, PC and fault are plain variables.
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    logic [31:0] m_pc;
    bit          m_fault;
    logic [31:0] m_fetch, m_stall;

    task automatic model_reset();
        q_pc.delete();
        q_instr.delete();
        m_pc    = RV;
        m_fault = 1'b0;
        m_fetch = 32'h0;
        m_stall = 32'h0;
    endtask

    // Advance the model across one rising edge using the inputs just driven.
    task automatic model_update();
        bit valid;
        if (!rst_n) begin
            model_reset();
            return;
        end
        valid = (q_pc.size() > 0);
        if (valid && !ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (valid && ready) begin
            $display("pop  pc=%h instr=%h", q_pc[0], q_instr[0]);
            void'(q_pc.pop_front());
            void'(q_instr.pop_front());
        end
        if (redirect) begin
            q_pc.delete();
            q_instr.delete();
            m_pc    = {target[31:2], 2'b00};
            m_fault = (target[1:0] != 2'b00);
        end else if (!m_fault && q_pc.size() < DEPTH) begin
            q_pc.push_back(m_pc);
            q_instr.push_back(imem[m_pc[9:2]]);
            m_pc = m_pc + 32'd4;
            if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
        end
    endtask

    task automatic compare();
        check("id_valid", {31'b0, id_valid}, {31'b0, q_pc.size() > 0});
        check("imem_addr", imem_addr, m_pc);
        check("fault", {31'b0, fault}, {31'b0, m_fault});
        if (q_pc.size() > 0) begin
            check("id_pc", id_pc, q_pc[0]);
            check("id_instr", id_instr, q_instr[0]);
            check("id_pc4", id_pc4, q_pc[0] + 32'd4);
        end
        check("fetch_cnt", fetch_cnt, PERF ? m_fetch : 32'h0);
        check("stall_cnt", stall_cnt, PERF ? m_stall : 32'h0);
    endtask

    // One cycle: check state at the falling edge, then drive inputs for the next rising edge.
    task automatic step(input bit r, input bit rdy, input bit rd, input logic [31:0] tgt);
        @(negedge clk);
        compare();
        rst_n    = r;
        ready    = rdy;
        redirect = rd;
        target   = tgt;
        model_update();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; target = 32'h0;
        model_reset();
        @(posedge clk);

        // Reset state, then streaming with decode always ready
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        check("stall_hold_addr", imem_addr, 32'h8);
        check("stall_hold_pc", id_pc, 32'h0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);

        // Redirect with a full FIFO
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h40);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

        // Misaligned redirect into FAULT, then recover with an aligned one
        step(1, 1, 1, 32'h42);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        check("fault_hold_addr", imem_addr, 32'h40);
        check("fault_flag", {31'b0, fault}, 32'h1);
        step(1, 1, 1, 32'h80);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

        // Reset mid-stream with a full FIFO
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        check("reset_addr", imem_addr, RV);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

        // Ten streaming cycles with three backpressure cycles
        for (int i = 0; i < 10; i++) step(1, !(i == 2 || i == 5 || i == 6), 0, 0);

        // PC wrap at the top of the address space
        step(1, 1, 1, 32'hFFFF_FFF4);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1200; i++) begin
            logic [31:0] tgt;
            tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFF8;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, tgt);
        end
        step(1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
